// File: rtl/rf_pkg.sv
// Shared constants for the register-file write arbiter slice.
package rf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;
    localparam int REQ_ALU    = 0;
    localparam int REQ_MEM    = 1;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } grant_idx_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on contention, or fixed priority to requester 0.
module rr_arb2
    import rf_pkg::*;
#(
    parameter int FIXED_PRI = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);

    grant_idx_e r_last_grant;

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = 2'b00;
            if (FIXED_PRI != 0 || r_last_grant == GNT_MEM) begin
                o_grant[REQ_ALU] = 1'b1;
            end else begin
                o_grant[REQ_MEM] = 1'b1;
            end
        end
    end

    // Starting from MEM makes the ALU win the first contention after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GNT_MEM;
        end else if (o_grant[REQ_ALU]) begin
            r_last_grant <= GNT_ALU;
        end else if (o_grant[REQ_MEM]) begin
            r_last_grant <= GNT_MEM;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback, fixes
// read-before-write with a one-cycle bypass, and counts stalled requester-cycles.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int CNT_W       = 16,
    parameter int FIXED_PRI   = 0,
    parameter int ZERO_REG_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0Valid,
    input  logic [ADDR_W-1:0] req0Addr,
    input  logic [DATA_W-1:0] req0Data,
    output logic              req0Ready,
    input  logic              req1Valid,
    input  logic [ADDR_W-1:0] req1Addr,
    input  logic [DATA_W-1:0] req1Data,
    output logic              req1Ready,
    input  logic [ADDR_W-1:0] rAddrA,
    input  logic [ADDR_W-1:0] rAddrB,
    output logic [ADDR_W-1:0] rfAddrA,
    output logic [ADDR_W-1:0] rfAddrB,
    output logic [ADDR_W-1:0] rfWAddr,
    output logic [DATA_W-1:0] rfWData,
    output logic              rfWriteEn,
    input  logic [DATA_W-1:0] rfDataA,
    input  logic [DATA_W-1:0] rfDataB,
    output logic [DATA_W-1:0] rDataA,
    output logic [DATA_W-1:0] rDataB,
    input  logic              clearStats,
    output logic [CNT_W-1:0]  stallCount
);

    localparam bit ZERO_EN = (ZERO_REG_EN != 0);

    logic [1:0]        w_grant;
    logic              w_stall;
    logic [ADDR_W-1:0] w_raddr  [2];
    logic [DATA_W-1:0] w_rfdata [2];
    logic [DATA_W-1:0] w_rdata  [2];
    logic              r_byp    [2];
    logic              r_zero   [2];
    logic [DATA_W-1:0] r_byp_data;
    logic [CNT_W-1:0]  r_stall_count;

    rr_arb2 #(.FIXED_PRI(FIXED_PRI)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   ({req1Valid, req0Valid}),
        .o_grant (w_grant)
    );

    // Readies are gated by rst_n so nothing is handshaken while reset is held.
    assign req0Ready = rst_n & w_grant[REQ_ALU];
    assign req1Ready = rst_n & w_grant[REQ_MEM];

    assign rfWAddr   = req1Ready ? req1Addr : req0Addr;
    assign rfWData   = req1Ready ? req1Data : req0Data;
    assign rfWriteEn = (req0Ready | req1Ready) &
                       ~(ZERO_EN & (rfWAddr == ADDR_W'(REG_ZERO)));

    assign rfAddrA     = rAddrA;
    assign rfAddrB     = rAddrB;
    assign w_raddr[0]  = rAddrA;
    assign w_raddr[1]  = rAddrB;
    assign w_rfdata[0] = rfDataA;
    assign w_rfdata[1] = rfDataB;
    assign rDataA      = w_rdata[0];
    assign rDataB      = w_rdata[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byp_data <= '0;
        end else begin
            r_byp_data <= rfWData;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_byp[gi]  <= 1'b0;
                    r_zero[gi] <= 1'b0;
                end else begin
                    r_byp[gi]  <= rfWriteEn && (rfWAddr == w_raddr[gi]);
                    r_zero[gi] <= ZERO_EN && (w_raddr[gi] == ADDR_W'(REG_ZERO));
                end
            end

            assign w_rdata[gi] = r_zero[gi] ? '0 :
                                 r_byp[gi]  ? r_byp_data : w_rfdata[gi];
        end
    endgenerate

    // At most one requester can be stalled per cycle, so this is a 0/1 increment.
    assign w_stall = (req0Valid & ~req0Ready) | (req1Valid & ~req1Ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (clearStats) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign stallCount = r_stall_count;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench with a scoreboard of expected grants, write fields, read data and
// stall counts; covers round-robin and fixed-priority instances.
module tb_rf_write_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Round-robin instance
    logic        req0Valid = 1'b0, req1Valid = 1'b0;
    logic [4:0]  req0Addr = '0, req1Addr = '0;
    logic [31:0] req0Data = '0, req1Data = '0;
    logic        req0Ready, req1Ready;
    logic [4:0]  rAddrA = '0, rAddrB = '0;
    logic [4:0]  rfAddrA, rfAddrB, rfWAddr;
    logic [31:0] rfWData, rDataA, rDataB;
    logic        rfWriteEn;
    logic [31:0] rfDataA = '0, rfDataB = '0;
    logic        clearStats = 1'b0;
    logic [15:0] stallCount;

    // Fixed-priority instance
    logic        fp_v0 = 1'b0, fp_v1 = 1'b0, fp_clr = 1'b0;
    logic        fp_r0, fp_r1, fp_we;
    logic [4:0]  fp_rfa, fp_rfb, fp_wa;
    logic [31:0] fp_wd, fp_da, fp_db;
    logic [15:0] fp_stall;

    rf_write_arbiter #(.FIXED_PRI(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0Valid(req0Valid), .req0Addr(req0Addr), .req0Data(req0Data), .req0Ready(req0Ready),
        .req1Valid(req1Valid), .req1Addr(req1Addr), .req1Data(req1Data), .req1Ready(req1Ready),
        .rAddrA(rAddrA), .rAddrB(rAddrB), .rfAddrA(rfAddrA), .rfAddrB(rfAddrB),
        .rfWAddr(rfWAddr), .rfWData(rfWData), .rfWriteEn(rfWriteEn),
        .rfDataA(rfDataA), .rfDataB(rfDataB), .rDataA(rDataA), .rDataB(rDataB),
        .clearStats(clearStats), .stallCount(stallCount)
    );

    rf_write_arbiter #(.FIXED_PRI(1), .CNT_W(16)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0Valid(fp_v0), .req0Addr(5'd5), .req0Data(32'hA), .req0Ready(fp_r0),
        .req1Valid(fp_v1), .req1Addr(5'd6), .req1Data(32'hB), .req1Ready(fp_r1),
        .rAddrA(5'd0), .rAddrB(5'd0), .rfAddrA(fp_rfa), .rfAddrB(fp_rfb),
        .rfWAddr(fp_wa), .rfWData(fp_wd), .rfWriteEn(fp_we),
        .rfDataA(32'h0), .rfDataB(32'h0), .rDataA(fp_da), .rDataB(fp_db),
        .clearStats(fp_clr), .stallCount(fp_stall)
    );

    // Register file model: synchronous read-before-write, preloaded on the first edge.
    logic        rf_load = 1'b1;
    logic [31:0] rf_mem [32];
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hC0DE0000 | 32'(i);
        end else if (rfWriteEn) begin
            rf_mem[rfWAddr] <= rfWData;
        end
        rfDataA <= rf_mem[rfAddrA];
        rfDataB <= rf_mem[rfAddrB];
    end

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t comb_q[$];
    exp_t reg_q[$];
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            0:  return {31'b0, req0Ready};
            1:  return {31'b0, req1Ready};
            2:  return {31'b0, rfWriteEn};
            3:  return {27'b0, rfWAddr};
            4:  return rfWData;
            5:  return rDataA;
            6:  return rDataB;
            7:  return {16'b0, stallCount};
            8:  return {31'b0, fp_r0};
            9:  return {31'b0, fp_r1};
            10: return {16'b0, fp_stall};
            default: return 'x;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_c(input string tag, input int sel, input logic [31:0] e);
        comb_q.push_back('{tag, sel, e});
    endtask

    task automatic push_r(input string tag, input int sel, input logic [31:0] e);
        reg_q.push_back('{tag, sel, e});
    endtask

    task automatic drain_comb();
        exp_t e;
        while (comb_q.size() > 0) begin
            e = comb_q.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic drain_reg();
        exp_t e;
        while (reg_q.size() > 0) begin
            e = reg_q.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; combinational outputs are
    // checked 1 unit later, registered outputs 1 unit after the following edge.
    task automatic cycle();
        #1;
        drain_comb();
        @(posedge clk);
        #1;
        drain_reg();
    endtask

    initial begin
        logic g1;

        // Reset with both requesters asserting valid
        req0Valid = 1'b1;
        req1Valid = 1'b1;
        #3;
        push_c("rst_req0Ready", 0, 0);
        push_c("rst_req1Ready", 1, 0);
        push_c("rst_rfWriteEn", 2, 0);
        push_c("rst_stallCount", 7, 0);
        push_c("rst_fp_stall", 10, 0);
        drain_comb();
        @(posedge clk);
        #1;
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        rst_n     = 1'b1;
        rf_load   = 1'b0;

        // Plain write of r3 then read it back through the register file
        req0Valid = 1'b1; req0Addr = 5'd3; req0Data = 32'h11;
        push_c("wr3_req0Ready", 0, 1);
        push_c("wr3_req1Ready", 1, 0);
        push_c("wr3_rfWriteEn", 2, 1);
        push_c("wr3_rfWAddr", 3, 3);
        push_c("wr3_rfWData", 4, 32'h11);
        cycle();
        req0Valid = 1'b0; rAddrA = 5'd3; rAddrB = 5'd3;
        push_c("idle_rfWriteEn", 2, 0);
        push_r("rd3_rDataA", 5, 32'h11);
        push_r("rd3_rDataB", 6, 32'h11);
        push_r("rd3_stall", 7, 0);
        cycle();

        // Round-robin contention; the last grant was the ALU so req1 goes first
        req0Valid = 1'b1; req0Addr = 5'd5; req0Data = 32'hA;
        req1Valid = 1'b1; req1Addr = 5'd6; req1Data = 32'hB;
        for (int i = 0; i < 4; i++) begin
            g1 = (i % 2 == 0);
            push_c($sformatf("rr%0d_req0Ready", i), 0, {31'b0, ~g1});
            push_c($sformatf("rr%0d_req1Ready", i), 1, {31'b0, g1});
            push_c($sformatf("rr%0d_rfWAddr", i), 3, g1 ? 32'd6 : 32'd5);
            push_c($sformatf("rr%0d_rfWData", i), 4, g1 ? 32'hB : 32'hA);
            push_r($sformatf("rr%0d_stall", i), 7, 32'(i + 1));
            cycle();
        end
        req0Valid = 1'b0; req1Valid = 1'b0;

        // Same-cycle write and read of r7 on both ports must bypass
        req0Valid = 1'b1; req0Addr = 5'd7; req0Data = 32'hDEADBEEF;
        rAddrA = 5'd7; rAddrB = 5'd7;
        push_c("byp_rfWriteEn", 2, 1);
        push_r("byp_rDataA", 5, 32'hDEADBEEF);
        push_r("byp_rDataB", 6, 32'hDEADBEEF);
        cycle();
        req0Valid = 1'b0;
        push_r("post_byp_rDataA", 5, 32'hDEADBEEF);
        push_r("post_byp_rDataB", 6, 32'hDEADBEEF);
        cycle();
        req1Valid = 1'b1; req1Addr = 5'd3; req1Data = 32'h22;
        rAddrA = 5'd3; rAddrB = 5'd6;
        push_c("mix_req1Ready", 1, 1);
        push_r("mix_rDataA_byp", 5, 32'h22);
        push_r("mix_rDataB_rf", 6, 32'hB);
        push_r("mix_stall", 7, 4);
        cycle();

        // Write to r0 is handshaken but dropped; r0 reads as zero
        req1Addr = 5'd0; req1Data = 32'h1234;
        rAddrA = 5'd0; rAddrB = 5'd0;
        push_c("z_req1Ready", 1, 1);
        push_c("z_rfWriteEn", 2, 0);
        push_r("z_rDataA", 5, 0);
        push_r("z_rDataB", 6, 0);
        cycle();
        req1Valid = 1'b0;
        push_r("z2_rDataA", 5, 0);
        cycle();

        // Make the ALU the last grant, then reset while a req0 write is pending
        req0Valid = 1'b1; req0Addr = 5'd8; req0Data = 32'h88;
        push_c("pre_req0Ready", 0, 1);
        cycle();
        req0Addr = 5'd9; req0Data = 32'h99;
        #1;
        push_c("mid_req0Ready_before", 0, 1);
        drain_comb();
        #1;
        rst_n = 1'b0;
        #1;
        push_c("mid_req0Ready_in_rst", 0, 0);
        push_c("mid_rfWriteEn_in_rst", 2, 0);
        drain_comb();
        @(posedge clk);
        #1;
        push_r("mid_stall_in_rst", 7, 0);
        drain_reg();
        rst_n = 1'b1;
        req0Addr = 5'd10; req0Data = 32'h1010;
        req1Valid = 1'b1; req1Addr = 5'd11; req1Data = 32'h1111;
        rAddrA = 5'd9;
        push_c("post_rst_req0Ready", 0, 1);
        push_c("post_rst_req1Ready", 1, 0);
        push_r("post_rst_r9_unwritten", 5, 32'hC0DE0009);
        push_r("post_rst_stall", 7, 1);
        cycle();
        req0Valid = 1'b0; req1Valid = 1'b0;

        // Fixed priority: req0 wins every cycle, counter saturates without wrapping
        fp_v0 = 1'b1; fp_v1 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            push_c($sformatf("fp%0d_req0Ready", k), 8, 1);
            push_c($sformatf("fp%0d_req1Ready", k), 9, 0);
            push_r($sformatf("fp%0d_stall", k), 10, 32'(k));
            cycle();
        end
        repeat (65534 - 3) @(posedge clk);
        #1;
        push_r("fp_stall_fffe", 10, 32'hFFFE);
        drain_reg();
        @(posedge clk);
        #1;
        push_r("fp_stall_ffff", 10, 32'hFFFF);
        drain_reg();
        repeat (3) @(posedge clk);
        #1;
        push_r("fp_stall_sat", 10, 32'hFFFF);
        push_c("fp_sat_req1Ready", 9, 0);
        drain_reg();
        drain_comb();
        fp_clr = 1'b1;
        push_r("fp_clear", 10, 0);
        cycle();
        fp_clr = 1'b0;
        push_r("fp_after_clear", 10, 1);
        cycle();
        fp_v0 = 1'b0; fp_v1 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
